// File: rtl/mf_pkg.sv
// Shared opcode definitions and the bitwise evaluation function for mf_gate_pipe.
// mf_eval works at a fixed maximum width; callers truncate to their own width.
package mf_pkg;

    typedef enum logic [2:0] {
        OP_X     = 3'b000,
        OP_Y     = 3'b001,
        OP_Y_ALT = 3'b010,
        OP_NX    = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_NAND  = 3'b111
    } mf_op_e;

    localparam int MF_MAX_W = 64;

    // Opcodes 000..011 keep the legacy single-bit gate truth table.
    function automatic logic [MF_MAX_W-1:0] mf_eval(
        input mf_op_e               op,
        input logic [MF_MAX_W-1:0]  x,
        input logic [MF_MAX_W-1:0]  y
    );
        logic [MF_MAX_W-1:0] r;
        r = x;
        case (op)
            OP_X:     r = x;
            OP_Y:     r = y;
            OP_Y_ALT: r = y;
            OP_NX:    r = ~x;
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_XOR:   r = x ^ y;
            OP_NAND:  r = ~(x & y);
            default:  r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mf_result_fifo.sv
// Single-clock result FIFO: control state is reset, storage is not.
// clr flushes everything, overriding any same-cycle push or pop.
module mf_result_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wr_data,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   OCC_ONE  = 1;
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (occupancy == OCC_FULL);
    assign empty   = (occupancy == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/mf_gate_pipe.sv
// Pipelined multifunction gate: bitwise op on accept, result plus zero/parity
// flags queued in a result FIFO, and a saturating accepted-transaction counter.
module mf_gate_pipe
    import mf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [2:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  f,
    output logic              f_zero,
    output logic              f_par,
    output logic [CNT_W-1:0]  count
);

    localparam int EW = WIDTH + 2;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [MF_MAX_W-1:0] eval_wide;
    logic [WIDTH-1:0]    res;
    logic [EW-1:0]       wr_data;
    logic [EW-1:0]       rd_data;
    logic                full;
    logic                empty;
    logic [AW:0]         occupancy;
    logic                accept;
    logic                pop;

    assign eval_wide = mf_eval(mf_op_e'(op), MF_MAX_W'(x), MF_MAX_W'(y));
    assign res       = eval_wide[WIDTH-1:0];
    assign wr_data   = {^res, ~|res, res};

    // in_ready depends only on stored occupancy, reset and clr, never on out_ready.
    assign in_ready  = rst_n && !clr && !full;
    assign accept    = in_valid && in_ready;
    assign out_valid = (occupancy != '0);
    assign pop       = out_ready && !empty;

    mf_result_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (accept),
        .pop       (pop),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    assign f      = rd_data[WIDTH-1:0];
    assign f_zero = rd_data[WIDTH];
    assign f_par  = rd_data[WIDTH+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mf_gate_pipe.sv
// Bench for mf_gate_pipe: directed handshake/flush/reset checks plus a
// queue-based scoreboard for every popped result; second instance for counter saturation.
module tb_mf_gate_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  f;
    logic        f_zero;
    logic        f_par;
    logic [15:0] count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_f;
    logic        s_f_zero;
    logic        s_f_par;
    logic [3:0]  s_count;

    int total = 0;
    int bad   = 0;
    logic [9:0] sb [$];

    always #5 clk = ~clk;

    mf_gate_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .f_zero(f_zero), .f_par(f_par), .count(count)
    );

    mf_gate_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .x(8'h5A), .y(8'hC3), .op(3'b110),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .f(s_f), .f_zero(s_f_zero), .f_par(s_f_par), .count(s_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd0:    return a;
            3'd1:    return b;
            3'd2:    return b;
            3'd3:    return ~a;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: decide at the falling edge what the next rising edge will do.
    always @(negedge clk) begin : mon
        logic [9:0] e;
        logic [7:0] r;
        if (!rst_n || clr) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_f", 32'(f), 32'(e[7:0]));
                    check("sb_zero", 32'(f_zero), 32'(e[8]));
                    check("sb_par", 32'(f_par), 32'(e[9]));
                end
            end
            if (in_valid && in_ready) begin
                r = ref_f(op, x, y);
                sb.push_back({^r, ~|r, r});
            end
        end
    end

    logic [7:0] exp_tab [8];
    int c0;

    initial begin
        exp_tab = '{8'hA5, 8'h3C, 8'h3C, 8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB};
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; op = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // All eight opcodes, one-cycle latency with free-flowing output
        out_ready = 1'b1; in_valid = 1'b1; x = 8'hA5; y = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            op = i[2:0];
            step();
            check($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("op%0d_f", i), 32'(f), 32'(exp_tab[i]));
            if (i == 4) begin
                check("op4_zero", 32'(f_zero), 32'd0);
                check("op4_par", 32'(f_par), 32'd0);
            end
        end
        x = 8'hFF; y = 8'hFF; op = 3'b110;
        step();
        check("xor_ff_f", 32'(f), 32'h00);
        check("xor_ff_zero", 32'(f_zero), 32'd1);
        check("xor_ff_par", 32'(f_par), 32'd0);
        x = 8'h07; op = 3'b000;
        step();
        check("par1_f", 32'(f), 32'h07);
        check("par1_par", 32'(f_par), 32'd1);
        in_valid = 1'b0;
        step();
        check("legacy_drained", 32'(out_valid), 32'd0);
        check("legacy_count", 32'(count), 32'd10);

        // Back-pressure with a two-entry FIFO
        out_ready = 1'b0; c0 = int'(count);
        in_valid = 1'b1; op = 3'b101; y = 8'h01;
        x = 8'h10; check("bp_rdy0", 32'(in_ready), 32'd1); step();
        x = 8'h20; check("bp_rdy1", 32'(in_ready), 32'd1); step();
        x = 8'h40; check("bp_full", 32'(in_ready), 32'd0); step();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_head", 32'(f), 32'h11);
        check("bp_count2", 32'(count), 32'(c0 + 2));
        out_ready = 1'b1;
        #1;
        check("bp_no_passthru", 32'(in_ready), 32'd0);
        step();
        check("bp_rdy_after_pop", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_count3", 32'(count), 32'(c0 + 3));

        // Concurrent push/pop at occupancy 1 across pointer wrap
        out_ready = 1'b0; in_valid = 1'b1; x = 8'h33; y = 8'h0F; op = 3'b100;
        step();
        out_ready = 1'b1; c0 = int'(count);
        for (int i = 0; i < 10; i++) begin
            x = 8'($urandom); y = 8'($urandom); op = 3'($urandom);
            step();
            check("cc_valid", 32'(out_valid), 32'd1);
            check("cc_ready", 32'(in_ready), 32'd1);
        end
        check("cc_count", 32'(count), 32'(c0 + 10));
        in_valid = 1'b0;
        step();
        check("cc_drained", 32'(out_valid), 32'd0);

        // Flush while full with a pending valid
        out_ready = 1'b0; in_valid = 1'b1;
        step(); step();
        check("clr_pre_full", 32'(in_ready), 32'd0);
        c0 = int'(count);
        clr = 1'b1;
        #1;
        check("clr_rdy_held", 32'(in_ready), 32'd0);
        step();
        clr = 1'b0;
        #1;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_count", 32'(count), 32'(c0));
        in_valid = 1'b0;

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst_rel_ready", 32'(in_ready), 32'd1);

        // Random traffic through the scoreboard
        for (int i = 0; i < 120; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            x = 8'($urandom); y = 8'($urandom); op = 3'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid; i++) begin
            step();
        end
        check("rand_drained", 32'(out_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // Counter saturation with a 4-bit counter
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        repeat (14) step();
        check("sat_14", 32'(s_count), 32'd14);
        repeat (6) step();
        check("sat_hold", 32'(s_count), 32'd15);
        check("sat_ready", 32'(s_in_ready), 32'd1);
        s_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mf_gate_pipe.md
Name: mf_gate_pipe

Overview:
Parametrised, pipelined successor to the single-bit multifunction gate. WIDTH-bit bitwise logic unit with a 3-bit opcode. Opcodes 000..011 reproduce the legacy {a,b} truth table: 00→x, 01→y, 10→y, 11→~x. Operations are accepted over a valid/ready handshake, buffered in a DEPTH-entry result FIFO with zero/parity flags, and counted in a saturating transaction counter. Sits between operand producers and downstream datapath consumers needing back-pressure.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DEPTH, 2, result FIFO entries (power of 2, >=2)
CNT_W, 16, width of accepted-transaction counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous FIFO flush
in_valid  in  1  operand/opcode valid
in_ready  out  1  unit can accept this cycle
x  in  WIDTH  operand X
y  in  WIDTH  operand Y
op  in  3  opcode
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
f  out  WIDTH  head result
f_zero  out  1  head result == 0
f_par  out  1  XOR-reduction of head result
count  out  CNT_W  accepted transactions, saturating

Behaviour:
- Opcodes: 000 x; 001 y; 010 y; 011 ~x; 100 x&y; 101 x|y; 110 x^y; 111 ~(x&y). All are bitwise across WIDTH.
- Push: accept = in_valid && in_ready. On accept, the result, zero flag, and parity flag are computed combinationally and written to the FIFO tail in the same edge.
- Latency: the result is visible on f/out_valid in the cycle after accept when the FIFO was empty (1-cycle latency). Otherwise it appears in order behind earlier entries.
- Pop: out_valid && out_ready removes the head. f/f_zero/f_par show the head entry and are don't-care when out_valid=0; the bench checks them only when valid.
- in_ready = (occupancy < DEPTH). It is registered-state only, with no combinational path from out_ready. When full, a same-cycle pop does not enable a push.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, head advances, tail advances.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits. out_valid = (occupancy != 0).
- clr: next edge sets pointers and occupancy to 0, dropping every entry including any same-cycle push and pop. in_ready is held 0 during a clr cycle, so no accept occurs and count does not increment. count itself is not cleared.
- count increments by 1 per accept and saturates at 2^CNT_W-1; it never wraps.
- Reset (rst_n=0, any time, including mid-transfer): occupancy 0, pointers 0, out_valid 0, in_ready 0 while asserted, count 0. FIFO storage contents are not reset. First accept is possible on the first edge after deassertion, when in_ready=1.
- Operand/opcode inputs are sampled only on accept; changes while in_ready=0 have no effect.

Decomposition:
- Shared package mf_pkg:
  - opcode enum: OP_X, OP_Y, OP_Y_ALT, OP_NX, OP_AND, OP_OR, OP_XOR, OP_NAND
  - function mf_eval(op, x, y) for reuse by the bench reference model
- One sub-module: mf_result_fifo. Synchronous single-clock FIFO parametrised on data width (WIDTH+2) and DEPTH, with push/pop/clr and full/empty/occupancy.
- The top holds the opcode decode, flag generation, handshake, and counter.

Test Plan:
- Legacy compatibility, WIDTH=8: x=8'hA5, y=8'h3C, op=000/001/010/011 with out_ready=1 → f=A5, 3C, 3C, 5A, each 1 cycle after accept.
- Extended ops, same operands: op=100/101/110/111 → f=24, BD, 99, DB. For f=8'h24: f_zero=0, f_par=0. For x=y=8'hFF, op=110: f=00, f_zero=1, f_par=0.
- Back-pressure, DEPTH=2, out_ready=0: three back-to-back valid ops → first two accepted, in_ready=0 on the third. Raising out_ready → results drain in order, third accepted the cycle after occupancy drops to 1.
- Concurrent push/pop at occupancy 1 for 10 cycles → occupancy stays 1, no loss or reorder across pointer wrap, count=+10.
- clr with occupancy 2 and in_valid=1 → next cycle out_valid=0, in_ready=1, count unchanged. Async rst_n pulse mid-stream → out_valid=0 and count=0 immediately, without waiting for a clock edge.
- Saturation with CNT_W=4: 20 accepts → count=15 and holds.
